bin2bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter for the lab's seven-segment time/score display path.
- Successor to the fixed 0–31 combinational decoder:
  - generic input width and digit count;
  - iterative shift-add-3 (double-dabble) engine, one bit per clock;
  - start/busy/done handshake.
- Inputs above a programmable limit saturate to all-nines, as the legacy decoder did.

---
 rtl/bin2bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 144 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Define BIN2BCD_LZB_EN to enable leading-zero blanking in bin2bcd_seq.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE  = 4'd9;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Counter must hold the value IN_W itself, not just IN_W-1.
    function automatic int cnt_width(input int in_w);
        return $clog2(in_w + 1);
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking when BIN2BCD_LZB_EN is defined.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W    = 6,
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = cnt_width(IN_W);
    localparam logic [IN_W-1:0] MAX_VEC = IN_W'(MAX_VAL);

    if (longint'(MAX_VAL) > pow10(DIGITS) - 1) begin : g_bad_digits
        $error("bin2bcd_seq: MAX_VAL does not fit in DIGITS decimal digits");
    end
    if (longint'(MAX_VAL) > (longint'(1) << IN_W) - 1) begin : g_bad_width
        $error("bin2bcd_seq: MAX_VAL does not fit in IN_W bits");
    end

    state_t             state_q, state_d;
    logic [IN_W-1:0]    sr_q, sr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [ACC_W-1:0]   bcd_out_q, bcd_out_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W-1:0]       acc_final;
    logic [ACC_W-1:0]       nines;
    logic [ACC_W+IN_W-1:0]  shifted;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .digit_in  (acc_q[gi*4 +: 4]),
                .digit_out (acc_adj[gi*4 +: 4])
            );
            assign nines[gi*4 +: 4] = BCD_NINE;
        end
    endgenerate

`ifdef BIN2BCD_LZB_EN
    // seen[gi]: some digit at position gi or above is nonzero; digit 0 always shown.
    logic [DIGITS-1:0] seen;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign seen[gi] = 1'b1;
            end else if (gi == DIGITS - 1) begin : g_msd
                assign seen[gi] = |acc_q[gi*4 +: 4];
            end else begin : g_mid
                assign seen[gi] = (|acc_q[gi*4 +: 4]) | seen[gi+1];
            end
            assign acc_final[gi*4 +: 4] = seen[gi] ? acc_q[gi*4 +: 4] : BCD_BLANK;
        end
    endgenerate
`else
    assign acc_final = acc_q;
`endif

    assign shifted = {acc_adj, sr_q} << 1;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        bcd_out_d = bcd_out_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin_in;
                    sat_d   = (bin_in > MAX_VEC);
                    acc_d   = '0;
                    cnt_d   = CNT_W'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shifted[ACC_W+IN_W-1:IN_W];
                sr_d  = shifted[IN_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Saturated runs still shift fully; their accumulator is discarded here.
                bcd_out_d = sat_q ? nines : acc_final;
                ovf_d     = sat_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            bcd_out_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            bcd_out_q <= bcd_out_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default instance (6b/2 digits) and a 10b/3 digit instance.
module tb_bin2bcd_seq;

    localparam int IN_A = 6;
    localparam int IN_B = 10;

`ifdef BIN2BCD_LZB_EN
    localparam logic [7:0]  EA0 = 8'hF0;
    localparam logic [7:0]  EA5 = 8'hF5;
    localparam logic [11:0] EB42 = 12'hF42;
    localparam logic [11:0] EB7  = 12'hFF7;
`else
    localparam logic [7:0]  EA0 = 8'h00;
    localparam logic [7:0]  EA5 = 8'h05;
    localparam logic [11:0] EB42 = 12'h042;
    localparam logic [11:0] EB7  = 12'h007;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start_a = 1'b0, busy_a, done_a, ovf_a;
    logic [IN_A-1:0] bin_a = '0;
    logic [7:0]      bcd_a;
    logic            start_b = 1'b0, busy_b, done_b, ovf_b;
    logic [IN_B-1:0] bin_b = '0;
    logic [11:0]     bcd_b;

    bin2bcd_seq #(.IN_W(IN_A), .DIGITS(2), .MAX_VAL(31)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a)
    );

    bin2bcd_seq #(.IN_W(IN_B), .DIGITS(3), .MAX_VAL(999)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b)
    );

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_spurious_done", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                $display("a done: bcd=%h ovf=%b cycle=%0d (expect %h %b %0d)", bcd_a, ovf_a, cyc, e.bcd[7:0], e.ovf, e.at);
                check("a_bcd", 32'(bcd_a), 32'(e.bcd[7:0]));
                check("a_ovf", 32'(ovf_a), 32'(e.ovf));
                check("a_latency", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_spurious_done", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                $display("b done: bcd=%h ovf=%b cycle=%0d (expect %h %b %0d)", bcd_b, ovf_b, cyc, e.bcd, e.ovf, e.at);
                check("b_bcd", 32'(bcd_b), 32'(e.bcd));
                check("b_ovf", 32'(ovf_b), 32'(e.ovf));
                check("b_latency", cyc, e.at);
            end
        end
    end

    // Start edge k is the next posedge; done is seen at the negedge after edge k+IN_W+1.
    task automatic issue_a(input logic [IN_A-1:0] v, input logic [7:0] eb, input logic eo);
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = v;
        q_a.push_back('{bcd: {4'h0, eb}, ovf: eo, at: cyc + IN_A + 2});
        $display("a start: bin=%0d", v);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic issue_b(input logic [IN_B-1:0] v, input logic [11:0] eb, input logic eo);
        @(negedge clk);
        start_b = 1'b1;
        bin_b   = v;
        q_b.push_back('{bcd: eb, ovf: eo, at: cyc + IN_B + 2});
        $display("b start: bin=%0d", v);
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(name, 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_bcd", 32'(bcd_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero input with busy window check.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 6'd0;
        q_a.push_back('{bcd: {4'h0, EA0}, ovf: 1'b0, at: cyc + IN_A + 2});
        $display("a start: bin=0");
        @(negedge clk);
        start_a = 1'b0;
        check("busy_c1", 32'(busy_a), 32'd1);
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", i), 32'(busy_a), 32'd1);
        end
        @(negedge clk);
        check("busy_done_state", 32'(busy_a), 32'd0);
        check("done_not_early", 32'(done_a), 32'd0);
        drain("drain_zero");

        issue_a(6'd31, 8'h31, 1'b0);
        drain("drain_31");
        issue_a(6'd32, 8'h99, 1'b1);
        drain("drain_32");
        issue_a(6'd63, 8'h99, 1'b1);
        drain("drain_63");
        issue_a(6'd5, EA5, 1'b0);
        drain("drain_5");
        issue_a(6'd40, 8'h99, 1'b1);
        drain("drain_40");

        // Second request while busy must be ignored, bin_in change has no effect.
        issue_a(6'd17, 8'h17, 1'b0);
        start_a = 1'b1;
        bin_a   = 6'd5;
        @(negedge clk);
        start_a = 1'b0;
        drain("drain_17");
        repeat (12) @(negedge clk);
        check("no_queued_start", 32'(q_a.size()), 32'd0);

        // Held start re-triggers on the first IDLE cycle after DONE.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 6'd31;
        base    = cyc + IN_A + 2;
        q_a.push_back('{bcd: 12'h031, ovf: 1'b0, at: base});
        q_a.push_back('{bcd: 12'h020, ovf: 1'b0, at: base + IN_A + 2});
        $display("a start held: bin=31 then 20");
        @(negedge clk);
        bin_a = 6'd20;
        repeat (8) @(negedge clk);
        start_a = 1'b0;
        drain("drain_retrigger");

        // Asynchronous reset mid-conversion abandons it.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 6'd25;
        $display("a start: bin=25 (to be reset)");
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("a async reset asserted");
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        check("arst_bcd", 32'(bcd_a), 32'd0);
        check("arst_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue_a(6'd12, 8'h12, 1'b0);
        drain("drain_12");

        // Wide instance.
        issue_b(10'd999, 12'h999, 1'b0);
        drain("drain_999");
        issue_b(10'd1000, 12'h999, 1'b1);
        drain("drain_1000");
        issue_b(10'd1023, 12'h999, 1'b1);
        drain("drain_1023");
        issue_b(10'd407, 12'h407, 1'b0);
        drain("drain_407");
        issue_b(10'd42, EB42, 1'b0);
        drain("drain_42");
        issue_b(10'd7, EB7, 1'b0);
        drain("drain_7");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
